// File: rtl/aes_lockstep_checker.sv
// Lockstep monitor for two aes_core outputs: skew-absorbing FIFOs,
// in-order pairwise compare, event count and sticky first-mismatch capture.
module aes_lockstep_checker #(
  parameter int DW               = 128,
  parameter int SKEW_DEPTH       = 4,
  parameter int CNT_W            = 32,
  parameter bit STOP_ON_MISMATCH = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             ref_valid_i,
  input  logic [DW-1:0]    ref_data_i,
  input  logic             dut_valid_i,
  input  logic [DW-1:0]    dut_data_i,
  output logic [CNT_W-1:0] cmp_count_o,
  output logic             alarm_o,
  output logic [CNT_W-1:0] mismatch_idx_o,
  output logic [DW-1:0]    mismatch_ref_o,
  output logic [DW-1:0]    mismatch_dut_o,
  output logic [DW-1:0]    mismatch_diff_o,
  output logic             overflow_o,
  output logic             idle_o
);

  localparam int AW = $clog2(SKEW_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ALARM = 2'd2;

  localparam logic [AW:0]    P_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [DW-1:0]    ref_mem [SKEW_DEPTH];
  logic [DW-1:0]    dut_mem [SKEW_DEPTH];
  logic [AW:0]      ref_wp;
  logic [AW:0]      ref_rp;
  logic [AW:0]      dut_wp;
  logic [AW:0]      dut_rp;
  logic             ref_empty;
  logic             ref_full;
  logic             dut_empty;
  logic             dut_full;
  logic             active;
  logic             pop;
  logic             ref_push;
  logic             dut_push;
  logic             drop;
  logic             differ;
  logic [DW-1:0]    ref_head;
  logic [DW-1:0]    dut_head;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  assign ref_empty = (ref_wp == ref_rp);
  assign dut_empty = (dut_wp == dut_rp);
  assign ref_full  = (ref_wp[AW] != ref_rp[AW]) &&
                     (ref_wp[AW-1:0] == ref_rp[AW-1:0]);
  assign dut_full  = (dut_wp[AW] != dut_rp[AW]) &&
                     (dut_wp[AW-1:0] == dut_rp[AW-1:0]);

  assign ref_head = ref_mem[ref_rp[AW-1:0]];
  assign dut_head = dut_mem[dut_rp[AW-1:0]];

  assign active = (state_q == S_RUN) && en_i && !rst_i && !clear_i;
  assign pop    = active && !ref_empty && !dut_empty;
  assign differ = pop && (ref_head != dut_head);

  // a full side still accepts when its head leaves in the same cycle
  assign ref_push = active && ref_valid_i && (!ref_full || pop);
  assign dut_push = active && dut_valid_i && (!dut_full || pop);
  assign drop     = active && !pop &&
                    ((ref_valid_i && ref_full) ||
                     (dut_valid_i && dut_full));

  assign cnt_inc = (cnt_q == C_MAX) ? cnt_q : cnt_q + C_ONE;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE):
        if (en_i) state_d = S_RUN;
      (state_q == S_RUN):
        if (!en_i)
          state_d = S_IDLE;
        else if (differ && STOP_ON_MISMATCH)
          state_d = S_ALARM;
      (state_q == S_ALARM):
        state_d = S_ALARM;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ref_push) ref_mem[ref_wp[AW-1:0]] <= ref_data_i;
    if (dut_push) dut_mem[dut_wp[AW-1:0]] <= dut_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q         <= S_IDLE;
      ref_wp          <= '0;
      ref_rp          <= '0;
      dut_wp          <= '0;
      dut_rp          <= '0;
      cnt_q           <= '0;
      alarm_o         <= 1'b0;
      mismatch_idx_o  <= '0;
      mismatch_ref_o  <= '0;
      mismatch_dut_o  <= '0;
      mismatch_diff_o <= '0;
      overflow_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ref_push) ref_wp <= ref_wp + P_ONE;
      if (dut_push) dut_wp <= dut_wp + P_ONE;
      if (pop) begin
        ref_rp <= ref_rp + P_ONE;
        dut_rp <= dut_rp + P_ONE;
        cnt_q  <= cnt_inc;
      end
      if (drop) overflow_o <= 1'b1;
      if (differ && !alarm_o) begin
        alarm_o         <= 1'b1;
        mismatch_idx_o  <= cnt_inc;
        mismatch_ref_o  <= ref_head;
        mismatch_dut_o  <= dut_head;
        mismatch_diff_o <= ref_head ^ dut_head;
      end
    end
  end

  assign cmp_count_o = cnt_q;
  assign idle_o      = ref_empty && dut_empty && (state_q != S_ALARM);

endmodule

// File: tb/tb_aes_lockstep_checker.sv
// Bench for aes_lockstep_checker: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_aes_lockstep_checker;

  localparam int DW = 128;
  localparam int D  = 4;
  localparam logic [DW-1:0] Z = '0;
  localparam logic [DW-1:0] K =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] ONE = 128'h1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear, en, en2, rv, dv;
  logic [DW-1:0] rd, dd;

  logic [31:0]   cnt, idx;
  logic          alarm, ovf, idle;
  logic [DW-1:0] mref, mdut, mdiff;

  logic [3:0]    cnt2, idx2;
  logic          alarm2, ovf2, idle2;
  logic [DW-1:0] mref2, mdut2, mdiff2;

  aes_lockstep_checker #(
    .DW(DW), .SKEW_DEPTH(D), .CNT_W(32), .STOP_ON_MISMATCH(1'b1)
  ) u0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
    .ref_valid_i(rv), .ref_data_i(rd),
    .dut_valid_i(dv), .dut_data_i(dd),
    .cmp_count_o(cnt), .alarm_o(alarm), .mismatch_idx_o(idx),
    .mismatch_ref_o(mref), .mismatch_dut_o(mdut),
    .mismatch_diff_o(mdiff), .overflow_o(ovf), .idle_o(idle)
  );

  aes_lockstep_checker #(
    .DW(DW), .SKEW_DEPTH(D), .CNT_W(4), .STOP_ON_MISMATCH(1'b0)
  ) u1 (
    .clk_i(clk), .rst_i(rst), .en_i(en2), .clear_i(clear),
    .ref_valid_i(rv), .ref_data_i(rd),
    .dut_valid_i(dv), .dut_data_i(dd),
    .cmp_count_o(cnt2), .alarm_o(alarm2), .mismatch_idx_o(idx2),
    .mismatch_ref_o(mref2), .mismatch_dut_o(mdut2),
    .mismatch_diff_o(mdiff2), .overflow_o(ovf2), .idle_o(idle2)
  );

  int n_chk = 0;
  int n_err = 0;

  // behavioural model of u0
  logic [DW-1:0] qr[$];
  logic [DW-1:0] qd[$];
  logic [31:0]   m_cnt, m_idx;
  logic [DW-1:0] m_ref, m_dut;
  bit            m_alarm, m_ovf, m_run, m_frz;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_tick();
    logic [DW-1:0] a, b;
    if (rst || clear) begin
      qr.delete();
      qd.delete();
      m_cnt = 0; m_idx = 0; m_ref = '0; m_dut = '0;
      m_alarm = 0; m_ovf = 0; m_run = 0; m_frz = 0;
    end else if (m_frz) begin
      m_frz = 1;
    end else if (!m_run) begin
      m_run = en;
    end else if (!en) begin
      m_run = 0;
    end else begin
      if (qr.size() > 0 && qd.size() > 0) begin
        a = qr.pop_front();
        b = qd.pop_front();
        if (m_cnt != 32'hffff_ffff) m_cnt++;
        if (a != b) begin
          if (!m_alarm) begin
            m_alarm = 1; m_idx = m_cnt; m_ref = a; m_dut = b;
          end
          m_frz = 1;
        end
      end
      if (rv) begin
        if (qr.size() < D) qr.push_back(rd);
        else m_ovf = 1;
      end
      if (dv) begin
        if (qd.size() < D) qd.push_back(dd);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("count", DW'(cnt), DW'(m_cnt));
    chk("alarm", DW'(alarm), DW'(m_alarm));
    chk("idx", DW'(idx), DW'(m_idx));
    chk("mref", mref, m_ref);
    chk("mdut", mdut, m_dut);
    chk("mdiff", mdiff, m_ref ^ m_dut);
    chk("overflow", DW'(ovf), DW'(m_ovf));
    chk("idle", DW'(idle),
        DW'(qr.size() == 0 && qd.size() == 0 && !m_frz));
  endtask

  task automatic step(input bit e, input bit c,
                      input bit r_v, input logic [DW-1:0] r_d,
                      input bit d_v, input logic [DW-1:0] d_d);
    en = e; clear = c;
    rv = r_v; rd = r_d; dv = d_v; dd = d_d;
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  logic [DW-1:0] words[$];
  logic [DW-1:0] w;
  logic [DW-1:0] s[10];
  int ri, di;
  bit e, c, acc, rvv, dvv;

  initial begin
    rst = 1'b1; en2 = 1'b0;
    step(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    step(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    chk("rst_idle", DW'(idle), ONE);
    chk("rst_idle2", DW'(idle2), ONE);
    chk("rst_count2", DW'(cnt2), Z);
    rst = 1'b0;

    // aligned match
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b1, K, 1'b1, K);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    chk("aligned_count", DW'(cnt), DW'(10));
    chk("aligned_alarm", DW'(alarm), Z);
    chk("aligned_idle", DW'(idle), ONE);

    // disabled: valids ignored
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, K, 1'b1, rnd128());
    chk("disabled_count", DW'(cnt), DW'(10));
    chk("disabled_idle", DW'(idle), ONE);

    // skew: reference leads by four
    step(1'b1, 1'b1, 1'b0, Z, 1'b0, Z);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    for (int i = 0; i < 10; i++) s[i] = rnd128();
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, s[i], 1'b0, Z);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b0, Z, 1'b1, s[i]);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    chk("skew_count", DW'(cnt), DW'(4));
    chk("skew_ovf", DW'(ovf), Z);
    chk("skew_alarm", DW'(alarm), Z);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b1, s[i+4], 1'b0, Z);
    chk("skew5_ovf", DW'(ovf), ONE);

    // push into a full FIFO while it pops
    step(1'b1, 1'b1, 1'b0, Z, 1'b0, Z);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, s[i], 1'b0, Z);
    step(1'b1, 1'b0, 1'b0, Z, 1'b1, s[0]);
    step(1'b1, 1'b0, 1'b1, s[4], 1'b1, s[1]);
    for (int i = 2; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, Z, 1'b1, s[i]);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    chk("fullpop_count", DW'(cnt), DW'(5));
    chk("fullpop_ovf", DW'(ovf), Z);
    chk("fullpop_alarm", DW'(alarm), Z);

    // randomized traffic with bounded skew
    step(1'b1, 1'b1, 1'b0, Z, 1'b0, Z);
    words.delete(); ri = 0; di = 0;
    for (int i = 0; i < 400; i++) begin
      e   = ($urandom_range(15) != 0);
      c   = ($urandom_range(127) == 0);
      acc = e && m_run && !m_frz && !c;
      rvv = ($urandom_range(1) == 1) && (ri - di < 3);
      dvv = ($urandom_range(1) == 1) && (di - ri < 3);
      while (words.size() <= ri || words.size() <= di)
        words.push_back(rnd128());
      step(e, c, rvv, words[ri], dvv, words[di]);
      if (c) begin
        words.delete(); ri = 0; di = 0;
      end else if (acc) begin
        if (rvv) ri++;
        if (dvv) di++;
      end
    end
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    chk("rand_alarm", DW'(alarm), Z);

    // injected mismatch on the third event
    step(1'b1, 1'b1, 1'b0, Z, 1'b0, Z);
    step(1'b1, 1'b0, 1'b0, Z, 1'b0, Z);
    step(1'b1, 1'b0, 1'b1, K, 1'b1, K);
    step(1'b1, 1'b0, 1'b1, K, 1'b1, K);
    step(1'b1, 1'b0, 1'b1, K, 1'b1, K ^ ONE);
    chk("mm_pre_alarm", DW'(alarm), Z);
    step(1'b1, 1'b0, 1'b1, K, 1'b1, K);
    chk("mm_alarm", DW'(alarm), ONE);
    chk("mm_idx", DW'(idx), DW'(3));
    chk("mm_diff", mdiff, ONE);
    chk("mm_dut", mdut, 128'h69c4e0d86a7b0430d8cdb78070b4c55b);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, K, 1'b1, K);
    chk("mm_frozen_count", DW'(cnt), DW'(3));
    chk("mm_idle", DW'(idle), Z);

    // clear during ALARM beats simultaneous valids
    step(1'b1, 1'b1, 1'b1, K, 1'b1, K);
    chk("clr_count", DW'(cnt), Z);
    chk("clr_alarm", DW'(alarm), Z);
    chk("clr_diff", mdiff, Z);
    chk("clr_idle", DW'(idle), ONE);

    // 4-bit counter saturation, non-stopping checker
    en2 = 1'b1;
    step(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    for (int i = 0; i < 20; i++) begin
      w = rnd128();
      step(1'b0, 1'b0, 1'b1, w, 1'b1, (i == 4) ? (w ^ ONE) : w);
    end
    step(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    step(1'b0, 1'b0, 1'b0, Z, 1'b0, Z);
    chk("sat_count", DW'(cnt2), DW'(15));
    chk("sat_alarm", DW'(alarm2), ONE);
    chk("sat_idx", DW'(idx2), DW'(5));
    chk("sat_diff", mdiff2, ONE);
    chk("sat_ovf", DW'(ovf2), Z);
    chk("sat_idle", DW'(idle2), ONE);
    chk("sat_main_count", DW'(cnt), Z);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_lockstep_checker.md
# aes_lockstep_checker

Hardware lockstep monitor that sits at the output end of two parallel `aes_core` instances: a reference core and a core under test. It consumes each core's ciphertext-valid event stream and absorbs bounded arrival skew between the two streams in small per-side FIFOs. It compares ciphertexts pairwise in event order, keeps a count of compared events, and latches the first mismatch (index, both words, XOR difference) as a sticky alarm for on-chip Trojan/fault detection.

## Interface
Parameters:
- `DW`, 128, ciphertext width in bits.
- `SKEW_DEPTH`, 4, entries per side FIFO (power of two, ≥2); maximum tolerated event skew.
- `CNT_W`, 32, width of the event counter and the mismatch index.
- `STOP_ON_MISMATCH`, 1, when 1 the checker freezes after the first mismatch; when 0 it keeps comparing.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `en_i`  in  1  enables capture and comparison.
- `clear_i`  in  1  synchronous soft clear, equivalent to reset.
- `ref_valid_i`  in  1  reference core output_valid pulse.
- `ref_data_i`  in  DW  reference core data_out; sampled when valid.
- `dut_valid_i`  in  1  core-under-test output_valid pulse.
- `dut_data_i`  in  DW  core-under-test data_out; sampled when valid.
- `cmp_count_o`  out  CNT_W  number of pairs compared; saturating.
- `alarm_o`  out  1  sticky; high after the first mismatch.
- `mismatch_idx_o`  out  CNT_W  1-based event number of the first mismatch.
- `mismatch_ref_o`  out  DW  reference word of the first mismatch.
- `mismatch_dut_o`  out  DW  test-core word of the first mismatch.
- `mismatch_diff_o`  out  DW  XOR of the two mismatch words.
- `overflow_o`  out  1  sticky; a valid arrived while its FIFO was full.
- `idle_o`  out  1  both FIFOs are empty and the state is not ALARM.

## Operation
- **States**
  - IDLE: entered on reset or clear. Moves to RUN when `en_i`=1.
  - RUN: moves back to IDLE when `en_i`=0. Moves to ALARM on a mismatch if `STOP_ON_MISMATCH`=1.
  - ALARM: terminal; left only by reset or clear.
- **Push**: in RUN, each side pushes its data into its own FIFO when its valid input is high.
- **Pop and compare**: in RUN, when both FIFOs are non-empty (registered flags), pop one entry from each and compare the pair.
- **Full FIFO**: a push to a full FIFO drops the word and sets `overflow_o`.
  - Exception: the push is accepted if the same FIFO pops in that cycle.
- **Counter**: `cmp_count_o` increments on every compared pair and saturates at 2^CNT_W−1.
- **First mismatch**: if the pair differs and `alarm_o`=0, the checker captures
  - `mismatch_idx_o` = the post-increment count,
  - `mismatch_ref_o`, `mismatch_dut_o`, `mismatch_diff_o`,
  - and sets `alarm_o`.
- **Later mismatches** (`STOP_ON_MISMATCH`=0): they do not overwrite the captured values; counting continues.
- **ALARM state**: no pushes and no pops; FIFO contents and `cmp_count_o` are frozen.
- **`en_i`=0 (IDLE)**: inputs are ignored, FIFO contents are held, no pops occur.
- **Reset or clear**: all outputs go to 0, both FIFOs are flushed, state returns to IDLE.
  - `clear_i` overrides valid inputs presented in the same cycle.

## Timing
- **Reset values**: every output is 0 except `idle_o`=1.
- **FIFO write**: a push at edge t is visible as non-empty from t+1. There is no bypass path.
- **Latency, aligned valids**: valids accepted at edge t → compare and pop at edge t+1 → `cmp_count_o`, `alarm_o` and the capture registers update at t+1 (visible after t+1).
- **Latency, skewed valids**: the compare happens one edge after the later side's push.
- **Skew tolerance**: up to `SKEW_DEPTH` outstanding events on one side without overflow.
- **Throughput**: one compare per cycle sustained, including back-to-back valids on both sides.
- **Wrap-around**: FIFO pointers wrap modulo `SKEW_DEPTH`. Full and empty are distinguished with an extra pointer bit.

## Test plan
- **Aligned match**: both sides present 69c4e0d86a7b0430d8cdb78070b4c55a for 10 cycles → `cmp_count_o`=10, `alarm_o`=0, `idle_o`=1 at the end.
- **Injected mismatch**: on the 3rd event the test core sends ...c55b → `alarm_o` rises one edge after that compare, `mismatch_idx_o`=3, `mismatch_diff_o`=…0001. With `STOP_ON_MISMATCH`=1, `cmp_count_o` stays at 3 under further valids.
- **Skew**: the reference side leads by 4 events, then the test core catches up → all pairs are compared in order, `cmp_count_o`=4, `overflow_o`=0. A 5th lead event → `overflow_o`=1.
- **Simultaneous push and pop on a full FIFO**: the word is accepted and `overflow_o` stays 0.
- **Enable and clear**: with `en_i`=0, valids are ignored and the count is unchanged. `clear_i` during ALARM returns all outputs to their reset values within one edge.
- **Saturation**: with `CNT_W`=4, 20 matching events → `cmp_count_o`=15.
